store_commit_unit: RTL and testbench
====================================

# store_commit_unit

Responder side of the commit-store handshake. Buffers execute-stage stores in program order; when the commit stage raises `commit_store_valid`, performs address translation on the oldest store, issues the write to the data cache, and returns a one-cycle `commit_store_ready` pulse with `commit_store_ex`. Sits between the LSU execute pipe, the TLB and the dcache SRAM-like request port.

## Interface
- `STQ_DEPTH`, 8: store queue entries (power of two).
- `clk  in  1`: clock.
- `reset  in  1`: reset, synchronous, active-high.
- `flush  in  1`: pipeline flush; discards all uncommitted stores.
- `st_enq_valid  in  1`: execute pushes a store.
- `st_enq_ready  out  1`: queue not full.
- `st_enq_vaddr  in  32`, `st_enq_wdata  in  32`, `st_enq_wstrb  in  4`, `st_enq_size  in  2`: store payload.
- `commit_store_valid  in  1`: ROB head or head+1 is in Store_Wait.
- `commit_store_ready  out  1`: one-cycle completion pulse.
- `commit_store_ex  out  exception_t`: ex, exccode, badvaddr, tlb_refill; all zero unless `commit_store_ready`.
- `tlb_req_valid  out  1`, `tlb_req_vaddr  out  32`: translation query.
- `tlb_resp_paddr  in  32`, `tlb_resp_miss  in  1`, `tlb_resp_invalid  in  1`, `tlb_resp_dirty  in  1`: response, valid the cycle after the query.
- `data_req  out  1`, `data_wr  out  1`, `data_size  out  2`, `data_addr  out  32`, `data_wstrb  out  4`, `data_wdata  out  32`: dcache request.
- `data_addr_ok  in  1`: request accepted this cycle.

## Operation
- Queue: circular, head/tail pointers with one extra wrap bit; `st_enq_ready` = count < STQ_DEPTH. Enqueue on `st_enq_valid && st_enq_ready && !flush`.
- FSM states: IDLE, TLB, CHECK, REQ, DONE.
  - IDLE -> TLB when `commit_store_valid && count != 0 && !flush`. `commit_store_valid` with empty queue: stay IDLE (protocol violation; bench asserts).
  - TLB: `tlb_req_valid`=1, `tlb_req_vaddr`=head vaddr; -> CHECK.
  - CHECK: latch paddr. miss -> exception TLBS (exccode 0x03), tlb_refill=1; invalid -> TLBS, tlb_refill=0; !dirty -> Mod (0x01). badvaddr=vaddr. Exception -> DONE (no cache request); else -> REQ.
  - REQ: `data_req` = !flush; `data_wr`=1; payload from head entry, `data_addr`=latched paddr. On `data_addr_ok` -> DONE.
  - DONE: `commit_store_ready`=1, `commit_store_ex` driven; head dequeued at end of cycle (both success and exception); -> IDLE.
- Flush in TLB/CHECK/REQ: -> IDLE, queue cleared, no ready pulse. `data_req` gated combinationally by `flush`, so no write is accepted in a flush cycle. Flush in DONE: pulse still emitted (store already committed to cache), then queue cleared.
- Simultaneous enqueue and dequeue: count unchanged. Flush beats enqueue.

## Timing
- Reset: IDLE, queue empty, `st_enq_ready`=1, all other outputs 0.
- Minimum latency, `commit_store_valid` sampled in cycle 0: `tlb_req_valid` cycle 1, `data_req` cycle 3, `commit_store_ready` cycle 4 (addr_ok in cycle 3). Each addr_ok stall cycle adds one.
- Exception path: ready with ex in cycle 3.
- Back-to-back: next store leaves IDLE no earlier than the cycle after DONE.
- Pointer arithmetic modulo STQ_DEPTH; wrap bit distinguishes full from empty.

## Configuration
- `STORE_TLB_EN` defined: TLB/CHECK states and TLB exceptions as above.
- Undefined: TLB ports tied 0; IDLE -> REQ directly with paddr = {3'b0, vaddr[28:0]}; `commit_store_ex` always zero; minimum latency `data_req` cycle 1, `commit_store_ready` cycle 2.

## Test plan
- Enqueue store vaddr 0x8000_0010, wdata 0xDEADBEEF, wstrb 0xF; commit; TLB paddr 0x0000_0010 dirty, addr_ok immediate -> data_addr 0x10, wdata 0xDEADBEEF, ready pulse cycle 4, ex=0, queue empty.
- Fill 8 entries -> `st_enq_ready`=0; commit one -> ready returns 1 the cycle after DONE; wrap tail through index 0 and commit all 8 in order.
- TLB miss on vaddr 0x0040_1234 -> ready cycle 3, ex=1, exccode 0x03, tlb_refill=1, badvaddr 0x0040_1234, no `data_req`; clean page -> exccode 0x01.
- Hold addr_ok low 5 cycles then flush in REQ -> `data_req` low in flush cycle, no ready pulse, queue empty, IDLE next cycle.
- Flush coincident with enqueue and with DONE -> enqueue dropped, ready pulse still emitted, count 0.
- Without `STORE_TLB_EN`: vaddr 0xA000_0100 -> data_addr 0x0000_0100, ready cycle 2, ex=0.

Source files
------------

// File: rtl/store_commit_unit.sv
// store_commit_unit
//   Responder side of the commit-store handshake. Execute-stage stores are
//   buffered in program order in a circular store queue. When the commit
//   stage raises commit_store_valid, the oldest store is translated (when
//   STORE_TLB_EN is defined), written to the data cache, and a one-cycle
//   commit_store_ready pulse is returned together with commit_store_ex.
//
// Build option:
//   STORE_TLB_EN  defined   : IDLE -> TLB -> CHECK -> REQ -> DONE, TLB faults
//                             (TLBS refill/invalid, Mod) reported on commit.
//                 undefined : TLB ports tied to 0, IDLE -> REQ directly with
//                             paddr = {3'b0, vaddr[28:0]}, commit_store_ex = 0.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   flush                 discard all uncommitted stores
//   st_enq_*              store push from execute (valid/ready + payload)
//   commit_store_valid    commit stage requests commit of the oldest store
//   commit_store_ready    one-cycle completion pulse
//   commit_store_ex       exception info, zero unless commit_store_ready
//   tlb_req_*/tlb_resp_*  translation query, response valid one cycle later
//   data_*                SRAM-like dcache write request, data_addr_ok accept

package store_commit_pkg;

  typedef struct packed {
    logic        ex;
    logic [4:0]  exccode;
    logic [31:0] badvaddr;
    logic        tlb_refill;
  } exception_t;

  localparam logic [4:0] EXC_MOD  = 5'h01;
  localparam logic [4:0] EXC_TLBS = 5'h03;

endpackage

module store_commit_unit
  import store_commit_pkg::*;
#(
  parameter int unsigned STQ_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,

  input  logic        st_enq_valid,
  output logic        st_enq_ready,
  input  logic [31:0] st_enq_vaddr,
  input  logic [31:0] st_enq_wdata,
  input  logic [3:0]  st_enq_wstrb,
  input  logic [1:0]  st_enq_size,

  input  logic        commit_store_valid,
  output logic        commit_store_ready,
  output exception_t  commit_store_ex,

  output logic        tlb_req_valid,
  output logic [31:0] tlb_req_vaddr,
  input  logic [31:0] tlb_resp_paddr,
  input  logic        tlb_resp_miss,
  input  logic        tlb_resp_invalid,
  input  logic        tlb_resp_dirty,

  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok
);

  localparam int unsigned PW      = (STQ_DEPTH > 1) ? $clog2(STQ_DEPTH) : 1;
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(STQ_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TLB,
    S_CHECK,
    S_REQ,
    S_DONE
  } state_t;

  state_t r_state;

  // ---------------------------------------------------------------------
  // Store queue: pointers carry one extra wrap bit so full and empty differ
  // ---------------------------------------------------------------------
  logic [PW:0]   r_head;
  logic [PW:0]   r_tail;
  logic [PW:0]   w_count;
  logic [PW-1:0] w_head_idx;
  logic [PW-1:0] w_tail_idx;

  logic [31:0] r_stq_vaddr [STQ_DEPTH];
  logic [31:0] r_stq_wdata [STQ_DEPTH];
  logic [3:0]  r_stq_wstrb [STQ_DEPTH];
  logic [1:0]  r_stq_size  [STQ_DEPTH];

  logic [31:0] w_head_vaddr;
  logic [31:0] w_head_wdata;
  logic [3:0]  w_head_wstrb;
  logic [1:0]  w_head_size;

  logic w_enq;
  logic w_deq;
  logic w_start;

  assign w_count      = r_tail - r_head;
  assign w_head_idx   = r_head[PW-1:0];
  assign w_tail_idx   = r_tail[PW-1:0];
  assign st_enq_ready = (w_count < DEPTH_C);

  assign w_head_vaddr = r_stq_vaddr[w_head_idx];
  assign w_head_wdata = r_stq_wdata[w_head_idx];
  assign w_head_wstrb = r_stq_wstrb[w_head_idx];
  assign w_head_size  = r_stq_size[w_head_idx];

  // Flush beats enqueue; the head leaves at the end of DONE on both the
  // success and the exception path.
  assign w_enq   = st_enq_valid && st_enq_ready && !flush;
  assign w_deq   = (r_state == S_DONE);
  assign w_start = commit_store_valid && (w_count != '0) && !flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PTR_ONE;
      if (w_deq) r_head <= r_head + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_stq_vaddr[w_tail_idx] <= st_enq_vaddr;
      r_stq_wdata[w_tail_idx] <= st_enq_wdata;
      r_stq_wstrb[w_tail_idx] <= st_enq_wstrb;
      r_stq_size[w_tail_idx]  <= st_enq_size;
    end
  end

  // ---------------------------------------------------------------------
  // Translation
  // ---------------------------------------------------------------------
  logic [31:0] w_req_paddr;
  exception_t  w_tlb_ex;

`ifdef STORE_TLB_EN
  logic        r_tlb_req_valid;
  logic [31:0] r_tlb_req_vaddr;

  assign tlb_req_valid = r_tlb_req_valid;
  assign tlb_req_vaddr = r_tlb_req_vaddr;
  assign w_req_paddr   = tlb_resp_paddr;

  // Miss outranks invalid, which outranks a clean-page write.
  always_comb begin
    w_tlb_ex = '0;
    if (tlb_resp_miss) begin
      w_tlb_ex.ex         = 1'b1;
      w_tlb_ex.exccode    = EXC_TLBS;
      w_tlb_ex.tlb_refill = 1'b1;
    end else if (tlb_resp_invalid) begin
      w_tlb_ex.ex         = 1'b1;
      w_tlb_ex.exccode    = EXC_TLBS;
    end else if (!tlb_resp_dirty) begin
      w_tlb_ex.ex         = 1'b1;
      w_tlb_ex.exccode    = EXC_MOD;
    end
    if (w_tlb_ex.ex) w_tlb_ex.badvaddr = w_head_vaddr;
  end
`else
  logic w_unused_tlb;

  assign tlb_req_valid = 1'b0;
  assign tlb_req_vaddr = '0;
  assign w_req_paddr   = {3'b000, w_head_vaddr[28:0]};
  assign w_tlb_ex      = '0;
  assign w_unused_tlb  = ^{tlb_resp_paddr, tlb_resp_miss, tlb_resp_invalid,
                           tlb_resp_dirty, w_head_vaddr[31:29], w_tlb_ex};
`endif

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  logic w_enter_req;
  logic w_leave_req;

`ifdef STORE_TLB_EN
  assign w_enter_req = (r_state == S_CHECK) && !flush && !w_tlb_ex.ex;
`else
  assign w_enter_req = (r_state == S_IDLE) && w_start;
`endif
  assign w_leave_req = (r_state == S_REQ) && (flush || data_addr_ok);

  logic        r_ready;
  exception_t  r_ex;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_ex    <= '0;
`ifdef STORE_TLB_EN
      r_tlb_req_valid <= 1'b0;
      r_tlb_req_vaddr <= '0;
`endif
    end else begin
      r_ready <= 1'b0;
      r_ex    <= '0;
`ifdef STORE_TLB_EN
      r_tlb_req_valid <= 1'b0;
      r_tlb_req_vaddr <= '0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
`ifdef STORE_TLB_EN
            r_state         <= S_TLB;
            r_tlb_req_valid <= 1'b1;
            r_tlb_req_vaddr <= w_head_vaddr;
`else
            r_state <= S_REQ;
`endif
          end
        end
`ifdef STORE_TLB_EN
        S_TLB: begin
          r_state <= flush ? S_IDLE : S_CHECK;
        end
        S_CHECK: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (w_tlb_ex.ex) begin
            // Faulting stores skip the cache and report straight away.
            r_state <= S_DONE;
            r_ready <= 1'b1;
            r_ex    <= w_tlb_ex;
          end else begin
            r_state <= S_REQ;
          end
        end
`endif
        S_REQ: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (data_addr_ok) begin
            r_state <= S_DONE;
            r_ready <= 1'b1;
          end
        end
        S_DONE: begin
          // The write already reached the cache, so a flush here still
          // lets the pulse out; the queue clear is handled by the pointers.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Cache request registers: loaded on entry to REQ, cleared on exit.
  logic        r_data_req;
  logic        r_data_wr;
  logic [1:0]  r_data_size;
  logic [31:0] r_data_addr;
  logic [3:0]  r_data_wstrb;
  logic [31:0] r_data_wdata;

  always_ff @(posedge clk) begin
    if (reset || w_leave_req) begin
      r_data_req   <= 1'b0;
      r_data_wr    <= 1'b0;
      r_data_size  <= '0;
      r_data_addr  <= '0;
      r_data_wstrb <= '0;
      r_data_wdata <= '0;
    end else if (w_enter_req) begin
      r_data_req   <= 1'b1;
      r_data_wr    <= 1'b1;
      r_data_size  <= w_head_size;
      r_data_addr  <= w_req_paddr;
      r_data_wstrb <= w_head_wstrb;
      r_data_wdata <= w_head_wdata;
    end
  end

  // Flush masks the request in the same cycle so the cache cannot accept
  // a store that is being discarded.
  assign data_req   = r_data_req && !flush;
  assign data_wr    = r_data_wr;
  assign data_size  = r_data_size;
  assign data_addr  = r_data_addr;
  assign data_wstrb = r_data_wstrb;
  assign data_wdata = r_data_wdata;

  assign commit_store_ready = r_ready;
  assign commit_store_ex    = r_ex;

endmodule

// File: tb/tb_store_commit_unit.sv
`timescale 1ns/1ps
module tb_store_commit_unit;
  import store_commit_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        st_enq_valid = 1'b0;
  logic        st_enq_ready;
  logic [31:0] st_enq_vaddr = '0;
  logic [31:0] st_enq_wdata = '0;
  logic [3:0]  st_enq_wstrb = '0;
  logic [1:0]  st_enq_size = '0;
  logic        commit_store_valid = 1'b0;
  logic        commit_store_ready;
  exception_t  commit_store_ex;
  logic        tlb_req_valid;
  logic [31:0] tlb_req_vaddr;
  logic [31:0] tlb_resp_paddr = '0;
  logic        tlb_resp_miss = 1'b0;
  logic        tlb_resp_invalid = 1'b0;
  logic        tlb_resp_dirty = 1'b1;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok = 1'b0;

  store_commit_unit #(.STQ_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .st_enq_valid(st_enq_valid), .st_enq_ready(st_enq_ready),
    .st_enq_vaddr(st_enq_vaddr), .st_enq_wdata(st_enq_wdata),
    .st_enq_wstrb(st_enq_wstrb), .st_enq_size(st_enq_size),
    .commit_store_valid(commit_store_valid), .commit_store_ready(commit_store_ready),
    .commit_store_ex(commit_store_ex),
    .tlb_req_valid(tlb_req_valid), .tlb_req_vaddr(tlb_req_vaddr),
    .tlb_resp_paddr(tlb_resp_paddr), .tlb_resp_miss(tlb_resp_miss),
    .tlb_resp_invalid(tlb_resp_invalid), .tlb_resp_dirty(tlb_resp_dirty),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] vaddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  size;
  } st_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  size;
  } wr_t;

  st_t        model_q[$];
  wr_t        exp_wr_q[$];
  exception_t exp_rdy_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  wr_t        mon_w;
  exception_t mon_x;

  always @(negedge clk) begin
    if (!reset) begin
      if (data_req && data_addr_ok) begin
        if (exp_wr_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_write: got addr %0h expected no write", data_addr);
        end else begin
          mon_w = exp_wr_q.pop_front();
          chk("data_addr",  64'(data_addr),  64'(mon_w.addr));
          chk("data_wdata", 64'(data_wdata), 64'(mon_w.wdata));
          chk("data_wstrb", 64'(data_wstrb), 64'(mon_w.wstrb));
          chk("data_size",  64'(data_size),  64'(mon_w.size));
          chk("data_wr",    64'(data_wr),    64'(1));
        end
      end
      if (commit_store_ready) begin
        if (exp_rdy_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_ready: got pulse expected none");
        end else begin
          mon_x = exp_rdy_q.pop_front();
          chk("ex.ex",         64'(commit_store_ex.ex),         64'(mon_x.ex));
          chk("ex.exccode",    64'(commit_store_ex.exccode),    64'(mon_x.exccode));
          chk("ex.badvaddr",   64'(commit_store_ex.badvaddr),   64'(mon_x.badvaddr));
          chk("ex.tlb_refill", 64'(commit_store_ex.tlb_refill), 64'(mon_x.tlb_refill));
        end
      end else begin
        chk("ex_zero_without_ready", 64'(commit_store_ex), 64'(0));
      end
    end
  end

  // ---------------- driver tasks (start/end at posedge+1) ----------------
  task automatic enq(input logic [31:0] va, input logic [31:0] wd,
                     input logic [3:0] ws, input logic [1:0] sz);
    st_t e;
    st_enq_valid = 1'b1;
    st_enq_vaddr = va; st_enq_wdata = wd; st_enq_wstrb = ws; st_enq_size = sz;
    chk("st_enq_ready", 64'(st_enq_ready), 64'(model_q.size() < DEPTH));
    if (model_q.size() < DEPTH) begin
      e.vaddr = va; e.wdata = wd; e.wstrb = ws; e.size = sz;
      model_q.push_back(e);
    end
    @(posedge clk); #1;
    st_enq_valid = 1'b0;
  endtask

  task automatic enq_rand();
    enq($urandom, $urandom, 4'($urandom), 2'($urandom));
  endtask

  // fm: 0 none, 1 flush in TLB, 2 flush in CHECK, 3 flush in REQ after
  // `stall` refused cycles, 4 flush (with an enqueue) in the DONE cycle.
  task automatic do_commit(input logic [31:0] paddr, input bit miss, input bit inv,
                           input bit dirty, input int stall, input int fm_in,
                           input bit enq_in_done);
    st_t        e;
    exception_t ex;
    wr_t        w;
    int         lat;
    int         fm;
    int         seen_req;
    bit         done;
    st_t        ne;
    e  = model_q[0];
    ex = '0;
    fm = fm_in;
`ifdef STORE_TLB_EN
    w.addr = paddr;
    if (miss) begin ex.ex = 1; ex.exccode = 5'h03; ex.tlb_refill = 1; end
    else if (inv) begin ex.ex = 1; ex.exccode = 5'h03; end
    else if (!dirty) begin ex.ex = 1; ex.exccode = 5'h01; end
    if (ex.ex) ex.badvaddr = e.vaddr;
    lat = ex.ex ? 3 : 4 + stall;
`else
    w.addr = {3'b000, e.vaddr[28:0]};
    lat = 2 + stall;
`endif
    tlb_resp_paddr = paddr; tlb_resp_miss = miss;
    tlb_resp_invalid = inv; tlb_resp_dirty = dirty;
    if (ex.ex && fm == 3) fm = 0;
    w.wdata = e.wdata; w.wstrb = e.wstrb; w.size = e.size;
    if (fm == 0 || fm == 4) begin
      exp_rdy_q.push_back(ex);
      if (!ex.ex) exp_wr_q.push_back(w);
    end

    commit_store_valid = 1'b1;
    data_addr_ok = 1'b0;
    seen_req = 0;
    done = 0;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(posedge clk); #1;
`ifdef STORE_TLB_EN
      if (c == 1) begin
        chk("tlb_req_valid", 64'(tlb_req_valid), 64'(1));
        chk("tlb_req_vaddr", 64'(tlb_req_vaddr), 64'(e.vaddr));
      end
`endif
      if (ex.ex) chk("no_data_req_on_ex", 64'(data_req), 64'(0));
      if ((fm == 1 && c == 1) || (fm == 2 && c == 2)) begin
        flush = 1'b1; commit_store_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("no_ready_after_flush", 64'(commit_store_ready), 64'(0));
        model_q.delete();
        done = 1;
      end else if (data_req) begin
        if (fm == 3 && seen_req == stall) begin
          flush = 1'b1; commit_store_valid = 1'b0; data_addr_ok = 1'b0;
          #1 chk("data_req_masked_by_flush", 64'(data_req), 64'(0));
          @(posedge clk); #1;
          flush = 1'b0;
          chk("no_ready_after_req_flush", 64'(commit_store_ready), 64'(0));
          chk("no_req_after_flush", 64'(data_req), 64'(0));
          model_q.delete();
          done = 1;
        end else begin
          data_addr_ok = (fm != 3) && (seen_req >= stall);
          seen_req++;
        end
      end else if (commit_store_ready) begin
        data_addr_ok = 1'b0;
        commit_store_valid = 1'b0;
        chk("ready_latency", 64'(c), 64'(lat));
        chk("enq_ready_in_done", 64'(st_enq_ready), 64'(model_q.size() < DEPTH));
        if (fm == 4 || enq_in_done) begin
          ne.vaddr = $urandom; ne.wdata = $urandom;
          ne.wstrb = 4'($urandom); ne.size = 2'($urandom);
          st_enq_valid = 1'b1;
          st_enq_vaddr = ne.vaddr; st_enq_wdata = ne.wdata;
          st_enq_wstrb = ne.wstrb; st_enq_size = ne.size;
          if (fm != 4 && model_q.size() < DEPTH) model_q.push_back(ne);
        end
        if (fm == 4) begin
          flush = 1'b1;
          model_q.delete();
        end else begin
          void'(model_q.pop_front());
        end
        @(posedge clk); #1;
        flush = 1'b0; st_enq_valid = 1'b0;
        chk("no_second_pulse", 64'(commit_store_ready), 64'(0));
        done = 1;
      end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL commit_timeout: got no completion expected ready within 60 cycles");
      commit_store_valid = 1'b0; data_addr_ok = 1'b0;
      flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
      model_q.delete(); exp_wr_q.delete(); exp_rdy_q.delete();
    end
    if (fm >= 1) chk("enq_ready_after_flush", 64'(st_enq_ready), 64'(1));
    commit_store_valid = 1'b0; data_addr_ok = 1'b0;
  endtask

  task automatic commit_ok(input int stall);
    do_commit($urandom, 1'b0, 1'b0, 1'b1, stall, 0, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int fm, r, rt, n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("reset_enq_ready", 64'(st_enq_ready), 64'(1));
    chk("reset_commit_ready", 64'(commit_store_ready), 64'(0));
    chk("reset_ex", 64'(commit_store_ex), 64'(0));
    chk("reset_tlb_req_valid", 64'(tlb_req_valid), 64'(0));
    chk("reset_data_req", 64'(data_req), 64'(0));
    chk("reset_data_wr", 64'(data_wr), 64'(0));
    chk("reset_data_addr", 64'(data_addr), 64'(0));

    // Directed store from the plan.
    enq(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'd2);
    do_commit(32'h0000_0010, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    chk("empty_after_first", 64'(model_q.size()), 64'(0));

    // Fill, overflow attempt, drain one, wrap tail through index 0, drain.
    for (int i = 0; i < DEPTH; i++) enq_rand();
    enq_rand();
    commit_ok(1);
    enq_rand();
    for (int i = 0; i < DEPTH; i++) commit_ok(i % 3);

`ifdef STORE_TLB_EN
    enq(32'h0040_1234, 32'h1111_2222, 4'h3, 2'd1);
    do_commit(32'h0000_1234, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
    enq(32'h0040_5678, 32'h3333_4444, 4'hF, 2'd2);
    do_commit(32'h0000_5678, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    enq(32'h0040_9ABC, 32'h5555_6666, 4'h1, 2'd0);
    do_commit(32'h0000_9ABC, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
`else
    enq(32'hA000_0100, 32'h0BAD_F00D, 4'hF, 2'd2);
    commit_ok(0);
`endif

    // Flush in REQ after 5 refused cycles, then flush coinciding with DONE.
    enq_rand(); enq_rand();
    do_commit($urandom, 1'b0, 1'b0, 1'b1, 5, 3, 1'b0);
    chk("empty_after_req_flush", 64'(model_q.size()), 64'(0));
    enq_rand(); enq_rand();
    do_commit($urandom, 1'b0, 1'b0, 1'b1, 0, 4, 1'b0);
    chk("empty_after_done_flush", 64'(model_q.size()), 64'(0));

    // Randomized traffic.
    for (int it = 0; it < 200; it++) begin
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) enq_rand();
      if (model_q.size() > 0) begin
        r  = $urandom_range(0, 9);
        fm = 0;
        if (r == 7) fm = 3;
        else if (r == 8) fm = 4;
`ifdef STORE_TLB_EN
        else if (r == 9) fm = $urandom_range(1, 2);
`endif
        rt = $urandom_range(0, 6);
        do_commit($urandom, rt == 0 || rt == 3, rt == 1 || rt == 3, rt != 2 && rt != 3,
                  (fm == 3) ? $urandom_range(0, 5) : $urandom_range(0, 3),
                  fm, 1'($urandom));
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_wr_q.size() + exp_rdy_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
